// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle scan controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    DUMP    = 2'd0,
    MEASURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int              POS_W   = 8;
  localparam logic [POS_W-1:0] POS_MAX = 8'hFF;

  // Scanlines past 255 saturate rather than wrap into the 8-bit position.
  function automatic logic [POS_W-1:0] clamp_line(input logic [8:0] line);
    return (line > 9'd255) ? POS_MAX : line[POS_W-1:0];
  endfunction

endpackage

// File: rtl/paddle_sync.sv
// Multi-stage synchronizer for one asynchronous paddle comparator input.
module paddle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/paddle_scan_ctrl.sv
// Per-frame RC paddle sequencer: dump, measure against vpos, commit at vsync.
// Optional macro PADDLE_AVG_FILTER_EN averages each new position with the previous one.
module paddle_scan_ctrl
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES  = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_LINE = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8:0]                   vpos,
  input  logic                         vsync,
  input  logic [NUM_PADDLES-1:0]       paddle_in,
  output logic                         paddle_dump,
  output logic [POS_W*NUM_PADDLES-1:0] paddle_pos,
  output logic [NUM_PADDLES-1:0]       paddle_timeout,
  output logic                         pos_valid,
  output logic                         busy
);

  localparam logic [8:0] TIMEOUT_V = TIMEOUT_LINE[8:0];

  state_t state_reg, state_next;
  logic   vsync_q;
  logic   rise, fall;
  logic   commit_en;
  logic   pos_valid_reg;
  logic   first_done;

  assign rise = vsync & ~vsync_q;
  assign fall = ~vsync & vsync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= DUMP;
      vsync_q       <= 1'b0;
      pos_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vsync_q       <= vsync;
      pos_valid_reg <= commit_en;
    end
  end

  // A rise in DUMP (no frame start seen yet) and a fall outside DUMP are ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DUMP:    if (fall) state_next = MEASURE;
      MEASURE: if (rise) state_next = COMMIT;
      COMMIT:  state_next = DUMP;
      default: state_next = DUMP;
    endcase
  end

  always_comb begin
    paddle_dump = 1'b0;
    busy        = 1'b0;
    commit_en   = 1'b0;
    case (state_reg)
      DUMP:    paddle_dump = 1'b1;
      MEASURE: busy        = 1'b1;
      COMMIT:  commit_en   = 1'b1;
      default: paddle_dump = 1'b1;
    endcase
  end

  assign pos_valid = pos_valid_reg;

`ifdef PADDLE_AVG_FILTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_done <= 1'b0;
    end else if (commit_en) begin
      first_done <= 1'b1;
    end
  end
`else
  assign first_done = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_pad
      logic             sync_in;
      logic             armed_reg;
      logic [POS_W-1:0] shadow_reg;
      logic             tshadow_reg;
      logic [POS_W-1:0] pos_reg;
      logic             timeout_reg;
      logic [POS_W:0]   avg_sum;

      paddle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (paddle_in[gi]),
        .dout  (sync_in)
      );

      // Level-sensitive capture: a comparator already high when armed captures at once.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          armed_reg   <= 1'b0;
          shadow_reg  <= '0;
          tshadow_reg <= 1'b0;
        end else begin
          case (state_reg)
            DUMP: begin
              armed_reg <= fall;
              if (fall) begin
                shadow_reg  <= '0;
                tshadow_reg <= 1'b0;
              end
            end
            MEASURE: begin
              if (armed_reg) begin
                if (rise) begin
                  shadow_reg  <= POS_MAX;
                  tshadow_reg <= 1'b1;
                  armed_reg   <= 1'b0;
                end else if (sync_in) begin
                  shadow_reg <= clamp_line(vpos);
                  armed_reg  <= 1'b0;
                end else if (vpos >= TIMEOUT_V) begin
                  shadow_reg  <= POS_MAX;
                  tshadow_reg <= 1'b1;
                  armed_reg   <= 1'b0;
                end
              end
            end
            default: armed_reg <= 1'b0;
          endcase
        end
      end

      assign avg_sum = {1'b0, pos_reg} + {1'b0, shadow_reg};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pos_reg     <= '0;
          timeout_reg <= 1'b0;
        end else if (commit_en) begin
          timeout_reg <= tshadow_reg;
          if (tshadow_reg || !first_done) begin
            pos_reg <= shadow_reg;
          end else begin
`ifdef PADDLE_AVG_FILTER_EN
            pos_reg <= avg_sum[POS_W:1];
`else
            pos_reg <= shadow_reg;
`endif
          end
        end
      end

      assign paddle_pos[POS_W*gi +: POS_W] = pos_reg;
      assign paddle_timeout[gi]            = timeout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_paddle_scan_ctrl.sv
// Scoreboard bench for paddle_scan_ctrl: two instances (timeout line 255 and 100) share stimulus.
module tb_paddle_scan_ctrl;

  localparam int LINE_CLKS = 8;
  localparam int N_LINES   = 262;
  localparam int VS_LINES  = 3;

  typedef struct packed {
    logic [31:0] pos;
    logic [3:0]  to;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  vpos;
  logic        vsync;
  logic [3:0]  paddle_in;

  logic        a_dump, a_valid, a_busy, b_dump, b_valid, b_busy;
  logic [31:0] a_pos, b_pos;
  logic [3:0]  a_to, b_to;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          p_line [4];
  bit   [3:0]  hold_mask = '0;
  rec_t        exp_q [2][$];
  rec_t        obs_q [2][$];
  logic [7:0]  m_prev [2][4];
  bit          m_first [2];
  int          to_line [2] = '{255, 100};

  always #5 clk = ~clk;

  paddle_scan_ctrl #(.NUM_PADDLES(4), .SYNC_STAGES(2), .TIMEOUT_LINE(255)) u_dut_a (
    .clk(clk), .reset(reset), .vpos(vpos), .vsync(vsync), .paddle_in(paddle_in),
    .paddle_dump(a_dump), .paddle_pos(a_pos), .paddle_timeout(a_to),
    .pos_valid(a_valid), .busy(a_busy)
  );

  paddle_scan_ctrl #(.NUM_PADDLES(4), .SYNC_STAGES(2), .TIMEOUT_LINE(100)) u_dut_b (
    .clk(clk), .reset(reset), .vpos(vpos), .vsync(vsync), .paddle_in(paddle_in),
    .paddle_dump(b_dump), .paddle_pos(b_pos), .paddle_timeout(b_to),
    .pos_valid(b_valid), .busy(b_busy)
  );

  always @(negedge clk) begin
    if (a_valid) obs_q[0].push_back(rec_t'{pos: a_pos, to: a_to});
    if (b_valid) obs_q[1].push_back(rec_t'{pos: b_pos, to: b_to});
  end

  // Reference model: expected committed positions given the per-paddle rise lines.
  task automatic push_expect();
    for (int d = 0; d < 2; d++) begin
      rec_t r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
        bit         t;
        logic [7:0] raw, v;
        t   = (p_line[i] < 0) || (p_line[i] >= to_line[d]);
        raw = t ? 8'hFF : 8'(p_line[i]);
`ifdef PADDLE_AVG_FILTER_EN
        v = (t || !m_first[d]) ? raw : 8'(({1'b0, m_prev[d][i]} + {1'b0, raw}) >> 1);
`else
        v = raw;
`endif
        r.pos[8*i +: 8] = v;
        r.to[i]         = t;
        m_prev[d][i]    = v;
      end
      m_first[d] = 1'b1;
      exp_q[d].push_back(r);
    end
  endtask

  task automatic drive_lines(input int first, input int last, input bit vs);
    for (int l = first; l <= last; l++) begin
      vpos  = 9'(l);
      vsync = vs;
      for (int i = 0; i < 4; i++)
        paddle_in[i] = hold_mask[i] | (!vs && p_line[i] >= 0 && l >= p_line[i]);
      repeat (LINE_CLKS) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int l0, input int l1, input int l2, input int l3);
    p_line = '{l0, l1, l2, l3};
    push_expect();
    drive_lines(VS_LINES, N_LINES - 1, 1'b0);
    drive_lines(0, VS_LINES - 1, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; vsync = 1'b1; vpos = '0; paddle_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_dump, a_busy, a_valid, a_pos, a_to} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_a: got dump=%b busy=%b valid=%b pos=%h to=%b, want 1 0 0 00000000 0000",
               a_dump, a_busy, a_valid, a_pos, a_to);
    end
    n_checks++;
    if ({b_dump, b_busy, b_valid, b_pos, b_to} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_b: got dump=%b busy=%b valid=%b pos=%h to=%b, want 1 0 0 00000000 0000",
               b_dump, b_busy, b_valid, b_pos, b_to);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_filter();
    run_frame(40, -1, -1, -1);
    run_frame(60, -1, -1, -1);
    run_frame(-1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() > 0) begin
        rec_t e, o;
        e = exp_q[d].pop_front();
        n_checks++;
        if (obs_q[d].size() == 0) begin
          n_fail++; $display("FAIL filter_valid dut%0d: no pos_valid, want pos=%h", d, e.pos);
        end else begin
          o = obs_q[d].pop_front();
          if (o.pos !== e.pos) begin n_fail++; $display("FAIL filter_pos dut%0d: got %h want %h", d, o.pos, e.pos); end
          n_checks++;
          if (o.to !== e.to) begin n_fail++; $display("FAIL filter_to dut%0d: got %b want %b", d, o.to, e.to); end
        end
      end
    end
    $display("test_filter done");
  endtask

  task automatic test_basic();
    run_frame(40, 200, -1, -1);
    run_frame(-1, -1, -1, 150);
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() > 0) begin
        rec_t e, o;
        e = exp_q[d].pop_front();
        n_checks++;
        if (obs_q[d].size() == 0) begin
          n_fail++; $display("FAIL basic_valid dut%0d: no pos_valid, want pos=%h", d, e.pos);
        end else begin
          o = obs_q[d].pop_front();
          if (o.pos !== e.pos) begin n_fail++; $display("FAIL basic_pos dut%0d: got %h want %h", d, o.pos, e.pos); end
          n_checks++;
          if (o.to !== e.to) begin n_fail++; $display("FAIL basic_to dut%0d: got %b want %b", d, o.to, e.to); end
        end
      end
    end
    $display("test_basic done");
  endtask

  task automatic test_preheld();
    hold_mask = 4'b0100;
    paddle_in = 4'b0100;
    repeat (16) @(negedge clk);
    n_checks++;
    if ({a_dump, a_busy} !== 2'b10) begin
      n_fail++; $display("FAIL preheld_dump_idle: got dump=%b busy=%b want 1 0", a_dump, a_busy);
    end
    p_line = '{-1, -1, 3, -1};
    push_expect();
    drive_lines(VS_LINES, 10, 1'b0);
    n_checks++;
    if ({a_dump, a_busy} !== 2'b01) begin
      n_fail++; $display("FAIL preheld_dump_measure: got dump=%b busy=%b want 0 1", a_dump, a_busy);
    end
    drive_lines(11, N_LINES - 1, 1'b0);
    hold_mask = '0;
    drive_lines(0, VS_LINES - 1, 1'b1);
    n_checks++;
    if ({a_dump, a_busy} !== 2'b10) begin
      n_fail++; $display("FAIL preheld_dump_after: got dump=%b busy=%b want 1 0", a_dump, a_busy);
    end
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() > 0) begin
        rec_t e, o;
        e = exp_q[d].pop_front();
        n_checks++;
        if (obs_q[d].size() == 0) begin
          n_fail++; $display("FAIL preheld_valid dut%0d: no pos_valid, want pos=%h", d, e.pos);
        end else begin
          o = obs_q[d].pop_front();
          if (o.pos !== e.pos) begin n_fail++; $display("FAIL preheld_pos dut%0d: got %h want %h", d, o.pos, e.pos); end
          n_checks++;
          if (o.to !== e.to) begin n_fail++; $display("FAIL preheld_to dut%0d: got %b want %b", d, o.to, e.to); end
        end
      end
    end
    $display("test_preheld done");
  endtask

  task automatic test_simul();
    run_frame(77, 77, -1, -1);
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() > 0) begin
        rec_t e, o;
        e = exp_q[d].pop_front();
        n_checks++;
        if (obs_q[d].size() == 0) begin
          n_fail++; $display("FAIL simul_valid dut%0d: no pos_valid, want pos=%h", d, e.pos);
        end else begin
          o = obs_q[d].pop_front();
          if (o.pos !== e.pos) begin n_fail++; $display("FAIL simul_pos dut%0d: got %h want %h", d, o.pos, e.pos); end
          n_checks++;
          if (o.to !== e.to) begin n_fail++; $display("FAIL simul_to dut%0d: got %b want %b", d, o.to, e.to); end
        end
      end
    end
    $display("test_simul done");
  endtask

  task automatic test_reset_mid();
    p_line = '{-1, -1, -1, -1};
    drive_lines(VS_LINES, 50, 1'b0);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_dump, a_busy, a_valid, a_pos, a_to} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_a: got dump=%b busy=%b valid=%b pos=%h to=%b, want 1 0 0 00000000 0000",
               a_dump, a_busy, a_valid, a_pos, a_to);
    end
    n_checks++;
    if ({b_dump, b_busy, b_valid, b_pos, b_to} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_b: got dump=%b busy=%b valid=%b pos=%h to=%b, want 1 0 0 00000000 0000",
               b_dump, b_busy, b_valid, b_pos, b_to);
    end
    @(negedge clk);
    reset = 1'b1;
    m_first = '{1'b0, 1'b0};
    drive_lines(51, N_LINES - 1, 1'b0);
    drive_lines(0, VS_LINES - 1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_q[d].size() != 0) begin
        n_fail++; $display("FAIL reset_mid_no_valid dut%0d: got %0d pulses want 0", d, obs_q[d].size());
        obs_q[d].delete();
      end
    end
    run_frame(-1, 120, -1, -1);
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() > 0) begin
        rec_t e, o;
        e = exp_q[d].pop_front();
        n_checks++;
        if (obs_q[d].size() == 0) begin
          n_fail++; $display("FAIL reset_mid_valid dut%0d: no pos_valid, want pos=%h", d, e.pos);
        end else begin
          o = obs_q[d].pop_front();
          if (o.pos !== e.pos) begin n_fail++; $display("FAIL reset_mid_pos dut%0d: got %h want %h", d, o.pos, e.pos); end
          n_checks++;
          if (o.to !== e.to) begin n_fail++; $display("FAIL reset_mid_to dut%0d: got %b want %b", d, o.to, e.to); end
        end
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    m_first = '{1'b0, 1'b0};
    test_reset();
    test_filter();
    test_basic();
    test_preheld();
    test_simul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
